// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one RV32I instruction at a time and drives the ALU control word and operands.
// It then captures the ALU result and branch outcome into a writeback/next-PC response.
// Latency: request accepted at edge N, response valid after edge N+1, so the response is seen at edge N+2.
// Backpressure: one instruction in flight; the response holds until out_ready; instr_ready is low outside IDLE.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   instr_valid/ready     request handshake
//   instruction, pc       raw RV32I word and its PC, sampled on accept only
//   rs1_data, rs2_data    register-file operands, sampled on accept only
//   ALU_Control, operand_A, operand_B, branch_op
//                         ALU drive, held from accept until the next accept
//   ALU_result, branch    combinational ALU outputs, sampled at the end of EXEC
//   out_valid/ready       response handshake
//   out_wb_en, out_rd, out_wb_data, out_branch_taken, out_next_pc, out_illegal
//                         response fields
//
// Build option: define ALU_ISSUE_ILLEGAL_EN to flag unsupported opcodes on out_illegal.
// Without it, out_illegal is tied low and unsupported opcodes retire silently as a NOP.

module alu_issue_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,

  output logic [5:0]      ALU_Control,
  output logic [XLEN-1:0] operand_A,
  output logic [XLEN-1:0] operand_B,
  output logic            branch_op,
  input  logic [XLEN-1:0] ALU_result,
  input  logic            branch,

  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_wb_en,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_wb_data,
  output logic            out_branch_taken,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // ---------------------------------------------------------------------------
  // Instruction field extraction
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [4:0]      rd_field;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] shamt_ext;
  logic [XLEN-1:0] req_pc_plus4;

  assign opcode    = instruction[6:0];
  assign rd_field  = instruction[11:7];
  assign funct3    = instruction[14:12];
  assign funct7_5  = instruction[30];

  assign imm_i     = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
  assign imm_u     = {instruction[31:12], 12'b0};
  assign imm_b     = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j     = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
  assign shamt_ext = {{(XLEN-5){1'b0}}, instruction[24:20]};

  assign req_pc_plus4 = pc + 32'd4;

  // ---------------------------------------------------------------------------
  // Decode: everything the ALU and the response path need, computed from the
  // request inputs so it can be registered on the accept edge.
  // ---------------------------------------------------------------------------
  logic [5:0]      dec_ctrl;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_branch_op;
  logic            dec_writes_rd;
  logic            dec_is_jump;
  logic [XLEN-1:0] dec_target;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic            dec_illegal;
`endif

  always_comb begin
    dec_ctrl      = 6'b000000;
    dec_a         = '0;
    dec_b         = '0;
    dec_branch_op = 1'b0;
    dec_writes_rd = 1'b0;
    dec_is_jump   = 1'b0;
    dec_target    = '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
    dec_illegal   = 1'b0;
`endif

    case (opcode)
      OPC_OP: begin
        dec_ctrl      = {2'b00, funct7_5, funct3};
        dec_a         = rs1_data;
        dec_b         = rs2_data;
        dec_writes_rd = 1'b1;
      end

      OPC_OP_IMM: begin
        // Only SRAI/SRLI use funct7[5]; for ADDI etc. bit 30 is immediate data.
        dec_ctrl      = {2'b00, (funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
        dec_a         = rs1_data;
        dec_b         = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_ext : imm_i;
        dec_writes_rd = 1'b1;
      end

      OPC_BRANCH: begin
        dec_ctrl      = {3'b010, funct3};
        dec_branch_op = 1'b1;
        dec_a         = rs1_data;
        dec_b         = rs2_data;
        dec_target    = pc + imm_b;
      end

      OPC_JAL: begin
        // The ALU passes operand A through, which yields the link address.
        dec_ctrl      = 6'b011111;
        dec_a         = req_pc_plus4;
        dec_writes_rd = 1'b1;
        dec_is_jump   = 1'b1;
        dec_target    = pc + imm_j;
      end

      OPC_JALR: begin
        dec_ctrl      = 6'b111111;
        dec_a         = req_pc_plus4;
        dec_writes_rd = 1'b1;
        dec_is_jump   = 1'b1;
        dec_target    = (rs1_data + imm_i) & ~32'h1;
      end

      OPC_LUI: begin
        dec_b         = imm_u;
        dec_writes_rd = 1'b1;
      end

      OPC_AUIPC: begin
        dec_a         = pc;
        dec_b         = imm_u;
        dec_writes_rd = 1'b1;
      end

      default: begin
        // Unsupported opcode: ALU idles on ADD 0+0 and the response is a NOP.
`ifdef ALU_ISSUE_ILLEGAL_EN
        dec_illegal   = 1'b1;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic accept;
  assign accept = instr_valid & instr_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        // Returning to IDLE (not straight to EXEC) keeps consume and accept in separate cycles.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request registers: ALU drive plus the context the response needs.
  // ---------------------------------------------------------------------------
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target_q;
  logic            wb_en_q;
  logic            is_jump_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic            illegal_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ALU_Control <= 6'b000000;
      operand_A   <= '0;
      operand_B   <= '0;
      branch_op   <= 1'b0;
      rd_q        <= '0;
      pc_q        <= '0;
      target_q    <= '0;
      wb_en_q     <= 1'b0;
      is_jump_q   <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q   <= 1'b0;
`endif
    end else if (accept) begin
      ALU_Control <= dec_ctrl;
      operand_A   <= dec_a;
      operand_B   <= dec_b;
      branch_op   <= dec_branch_op;
      rd_q        <= rd_field;
      pc_q        <= pc;
      target_q    <= dec_target;
      wb_en_q     <= dec_writes_rd & (rd_field != 5'd0);
      is_jump_q   <= dec_is_jump;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q   <= dec_illegal;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Response capture on the EXEC -> RESP edge
  // ---------------------------------------------------------------------------
  logic            exec_taken;
  logic [XLEN-1:0] exec_pc_plus4;

  // branch_op doubles as the is-branch flag, so a stray branch input is ignored elsewhere.
  assign exec_taken    = is_jump_q | (branch_op & branch);
  assign exec_pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_wb_en        <= 1'b0;
      out_rd           <= '0;
      out_wb_data      <= '0;
      out_branch_taken <= 1'b0;
      out_next_pc      <= '0;
    end else if (state_q == EXEC) begin
      out_wb_en        <= wb_en_q;
      out_rd           <= rd_q;
      out_wb_data      <= ALU_result;
      out_branch_taken <= exec_taken;
      out_next_pc      <= exec_taken ? target_q : exec_pc_plus4;
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic out_illegal_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_illegal_q <= 1'b0;
    end else if (state_q == EXEC) begin
      out_illegal_q <= illegal_q;
    end
  end

  assign out_illegal = out_illegal_q;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [5:0]  ALU_Control;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        branch_op;
  logic [31:0] ALU_result;
  logic        branch;
  logic        out_valid;
  logic        out_ready;
  logic        out_wb_en;
  logic [4:0]  out_rd;
  logic [31:0] out_wb_data;
  logic        out_branch_taken;
  logic [31:0] out_next_pc;
  logic        out_illegal;

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  alu_issue_ctrl #(.XLEN(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instruction      (instruction),
    .pc               (pc),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .ALU_Control      (ALU_Control),
    .operand_A        (operand_A),
    .operand_B        (operand_B),
    .branch_op        (branch_op),
    .ALU_result       (ALU_result),
    .branch           (branch),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_wb_en        (out_wb_en),
    .out_rd           (out_rd),
    .out_wb_data      (out_wb_data),
    .out_branch_taken (out_branch_taken),
    .out_next_pc      (out_next_pc),
    .out_illegal      (out_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Small behavioural ALU covering the operations the vectors use.
  always_comb begin
    ALU_result = 32'h0;
    branch     = 1'b0;
    case (ALU_Control)
      6'b000000: ALU_result = operand_A + operand_B;
      6'b001000: ALU_result = operand_A - operand_B;
      6'b001101: ALU_result = $signed(operand_A) >>> operand_B[4:0];
      6'b010000: branch     = (operand_A == operand_B);
      6'b010100: branch     = ($signed(operand_A) < $signed(operand_B));
      6'b011111: ALU_result = operand_A;
      6'b111111: ALU_result = operand_A;
      default:   ALU_result = 32'h0;
    endcase
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        bop;
    logic        wb_en;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        taken;
    logic [31:0] npc;
  } vec_t;

  vec_t vecs [12];

  int n_chk;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Full issue/response cycle with out_ready held high.
  task automatic run_vec(input string tag, input vec_t v, input logic exp_ill);
    @(negedge clock);
    instruction = v.instr;
    pc          = v.pc;
    rs1_data    = v.rs1;
    rs2_data    = v.rs2;
    instr_valid = 1'b1;
    out_ready   = 1'b1;
    check({tag, " instr_ready"}, {31'b0, instr_ready}, 32'd1);
    @(negedge clock);                       // accept edge passed: in EXEC
    instr_valid = 1'b0;
    instruction = 32'hDEADBEEF;             // inputs may change after accept
    pc          = 32'h0BAD0BAD;
    rs1_data    = 32'h12121212;
    rs2_data    = 32'h34343434;
    check({tag, " ctrl"},      {26'b0, ALU_Control}, {26'b0, v.ctrl});
    check({tag, " opA"},       operand_A, v.a);
    check({tag, " opB"},       operand_B, v.b);
    check({tag, " branch_op"}, {31'b0, branch_op}, {31'b0, v.bop});
    check({tag, " exec valid"}, {31'b0, out_valid}, 32'd0);
    @(negedge clock);                       // EXEC->RESP edge passed
    check({tag, " resp valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, " wb_en"},      {31'b0, out_wb_en}, {31'b0, v.wb_en});
    if (v.wb_en) begin
      check({tag, " rd"},      {27'b0, out_rd}, {27'b0, v.rd});
      check({tag, " wb_data"}, out_wb_data, v.wb);
    end
    check({tag, " taken"},   {31'b0, out_branch_taken}, {31'b0, v.taken});
    check({tag, " next_pc"}, out_next_pc, v.npc);
    check({tag, " illegal"}, {31'b0, out_illegal}, {31'b0, exp_ill});
    @(negedge clock);                       // consumed
    check({tag, " consumed"}, {30'b0, out_valid, instr_ready}, 32'b01);
  endtask

  initial begin
    vec_t lw_v;
    n_chk = 0;
    n_pass = 0;

    vecs[0]  = '{32'h002081B3, 32'h00001000, 32'd4, 32'd5, 6'h00, 32'd4, 32'd5,
                 1'b0, 1'b1, 5'd3, 32'd9, 1'b0, 32'h00001004};
    vecs[1]  = '{32'h40335293, 32'h00001004, 32'hFFFFFC18, 32'h0, 6'h0D, 32'hFFFFFC18, 32'd3,
                 1'b0, 1'b1, 5'd5, 32'hFFFFFF83, 1'b0, 32'h00001008};
    vecs[2]  = '{32'h0020C863, 32'h00000100, 32'hFFFFFFFE, 32'hFFFFFFFF, 6'h14, 32'hFFFFFFFE, 32'hFFFFFFFF,
                 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h00000110};
    vecs[3]  = '{32'h0020C863, 32'h00000100, 32'hFFFFFFFF, 32'hFFFFFFFE, 6'h14, 32'hFFFFFFFF, 32'hFFFFFFFE,
                 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h00000104};
    vecs[4]  = '{32'h003280E7, 32'h00000040, 32'h00000201, 32'h0, 6'h3F, 32'h00000044, 32'h0,
                 1'b0, 1'b1, 5'd1, 32'h00000044, 1'b1, 32'h00000204};
    vecs[5]  = '{32'h008000EF, 32'h00000200, 32'h0, 32'h0, 6'h1F, 32'h00000204, 32'h0,
                 1'b0, 1'b1, 5'd1, 32'h00000204, 1'b1, 32'h00000208};
    vecs[6]  = '{32'h123453B7, 32'h00000300, 32'h0, 32'h0, 6'h00, 32'h0, 32'h12345000,
                 1'b0, 1'b1, 5'd7, 32'h12345000, 1'b0, 32'h00000304};
    vecs[7]  = '{32'h00001417, 32'h00003000, 32'h0, 32'h0, 6'h00, 32'h00003000, 32'h00001000,
                 1'b0, 1'b1, 5'd8, 32'h00004000, 1'b0, 32'h00003004};
    vecs[8]  = '{32'h00508013, 32'h00000010, 32'd7, 32'h0, 6'h00, 32'd7, 32'd5,
                 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h00000014};
    vecs[9]  = '{32'hFFF08493, 32'h00000020, 32'h00000010, 32'h0, 6'h00, 32'h00000010, 32'hFFFFFFFF,
                 1'b0, 1'b1, 5'd9, 32'h0000000F, 1'b0, 32'h00000024};
    vecs[10] = '{32'h40208533, 32'h00000030, 32'd3, 32'd5, 6'h08, 32'd3, 32'd5,
                 1'b0, 1'b1, 5'd10, 32'hFFFFFFFE, 1'b0, 32'h00000034};
    vecs[11] = '{32'hFE000EE3, 32'h00000000, 32'h0, 32'h0, 6'h10, 32'h0, 32'h0,
                 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFFFFFC};

    reset       = 1'b1;
    instr_valid = 1'b0;
    out_ready   = 1'b0;
    instruction = 32'h0;
    pc          = 32'h0;
    rs1_data    = 32'h0;
    rs2_data    = 32'h0;

    // Reset state
    #1;
    check("reset instr_ready", {31'b0, instr_ready}, 32'd1);
    check("reset out_valid",   {31'b0, out_valid}, 32'd0);
    check("reset ctrl",        {26'b0, ALU_Control}, 32'd0);
    check("reset opA/opB",     operand_A | operand_B, 32'd0);
    check("reset resp",        {out_wb_en, out_branch_taken, out_illegal, branch_op, 23'b0, out_rd},
                               32'd0);
    check("reset wb/npc",      out_wb_data | out_next_pc, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i], 1'b0);
    end

    // Backpressure: ADD response held while a SUB request waits.
    @(negedge clock);
    instruction = vecs[0].instr; pc = vecs[0].pc;
    rs1_data = vecs[0].rs1; rs2_data = vecs[0].rs2;
    instr_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);                       // EXEC
    instruction = vecs[10].instr; pc = vecs[10].pc;
    rs1_data = vecs[10].rs1; rs2_data = vecs[10].rs2;
    @(negedge clock);                       // RESP
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d valid/ready", c), {30'b0, out_valid, instr_ready}, 32'b10);
      check($sformatf("bp%0d wb_data", c), out_wb_data, 32'd9);
      check($sformatf("bp%0d rd/wb_en/npc", c), {out_next_pc[26:0], out_rd},
            {27'h00001004, 5'd3} | {31'b0, ~out_wb_en});
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);                       // consume edge: no accept on it
    check("bp release valid/ready", {30'b0, out_valid, instr_ready}, 32'b01);
    check("bp no overlap ctrl", {26'b0, ALU_Control}, 32'h00);
    @(negedge clock);                       // SUB accepted now
    instr_valid = 1'b0;
    check("bp next ctrl", {26'b0, ALU_Control}, 32'h08);
    @(negedge clock);
    check("bp next wb_data", out_wb_data, 32'hFFFFFFFE);
    @(negedge clock);
    check("bp next consumed", {31'b0, out_valid}, 32'd0);

    // Reset asserted mid-EXEC
    @(negedge clock);
    instruction = vecs[10].instr; pc = vecs[10].pc;
    rs1_data = vecs[10].rs1; rs2_data = vecs[10].rs2;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    check("mid exec ctrl", {26'b0, ALU_Control}, 32'h08);
    #1 reset = 1'b1;
    #1;
    check("async rst instr_ready", {31'b0, instr_ready}, 32'd1);
    check("async rst ctrl",        {26'b0, ALU_Control}, 32'd0);
    check("async rst opA",         operand_A, 32'd0);
    check("async rst opB",         operand_B, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post rst out_valid", {31'b0, out_valid}, 32'd0);

    // Unsupported opcode (lw x0,0(x0))
    lw_v = '{32'h00002003, 32'h00000500, 32'h00000055, 32'h00000066, 6'h00, 32'h0, 32'h0,
             1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h00000504};
    run_vec("lw", lw_v, ILL_EN);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/sequencing controller that sits in front of the RV32I ALU and drives it. It accepts one decoded-operand instruction at a time and generates the ALU's `ALU_Control`, `operand_A`, `operand_B` and `branch_op`. It then captures `ALU_result`/`branch` and returns a writeback/next-PC response to the core. It is the control-side counterpart of the ALU, replacing ad-hoc driving of its control word.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: instruction request valid.
- `instr_ready` out 1: controller can accept a request.
- `instruction` in 32: raw RV32I instruction word.
- `pc` in 32: PC of the instruction.
- `rs1_data` in 32: register-file read of rs1.
- `rs2_data` in 32: register-file read of rs2.
- `ALU_Control` out 6: ALU operation code.
- `operand_A` out 32: ALU operand A.
- `operand_B` out 32: ALU operand B.
- `branch_op` out 1: ALU evaluates a branch compare.
- `ALU_result` in 32: combinational ALU result.
- `branch` in 1: combinational ALU branch outcome.
- `out_valid` out 1: response valid.
- `out_ready` in 1: consumer accepts the response.
- `out_wb_en` out 1: write `out_wb_data` to `out_rd`.
- `out_rd` out 5: destination register.
- `out_wb_data` out 32: writeback value.
- `out_branch_taken` out 1: control transfer taken.
- `out_next_pc` out 32: next PC.
- `out_illegal` out 1: unsupported opcode.

## Operation
- **FSM states:** IDLE → EXEC → RESP → IDLE.
  - `instr_ready` = (state==IDLE).
  - IDLE→EXEC on `instr_valid & instr_ready`.
  - EXEC→RESP unconditionally.
  - RESP→IDLE on `out_ready`.
- **On accept, register:** `ALU_Control`, `operand_A`, `operand_B`, `branch_op`, rd, pc, and the target. These outputs hold stable through EXEC and RESP.
- **ALU_Control encoding:**
  - OP (0110011): {2'b00, f7[5], f3}.
  - OP-IMM (0010011): {2'b00, (f3==3'b101)?f7[5]:1'b0, f3}.
  - BRANCH (1100011): {3'b010, f3}, with `branch_op`=1.
  - JAL: 6'b011111.
  - JALR: 6'b111111.
  - LUI/AUIPC: 6'b000000.
  - `branch_op`=0 for every non-branch opcode.
- **Operands:**
  - OP: A=rs1, B=rs2.
  - OP-IMM: A=rs1, B=sext(imm_i). For shifts B={27'b0, instr[24:20]}.
  - BRANCH: A=rs1, B=rs2.
  - JAL/JALR: A=pc+4, B=0 (the ALU passes A through).
  - LUI: A=0, B=imm_u.
  - AUIPC: A=pc, B=imm_u.
- **Target (own adder, not the ALU):**
  - BRANCH: pc+sext(imm_b).
  - JAL: pc+sext(imm_j).
  - JALR: (rs1+sext(imm_i)) & ~32'h1.
  - All arithmetic is mod 2^32; wrap-around is silent.
- **At EXEC, capture:**
  - `out_wb_data`=`ALU_result`.
  - `out_branch_taken` = `branch` for BRANCH, 1 for JAL/JALR, 0 otherwise.
  - `out_next_pc` = taken ? target : pc+4.
- **Writeback enable:** `out_wb_en` = 1 for OP/OP-IMM/LUI/AUIPC/JAL/JALR, and 0 for BRANCH. It is forced to 0 when rd==0.
- **Unsupported opcodes** (load, store, fence, system, others) are handled per Configuration.

## Timing
- **Reset values:**
  - State=IDLE; `instr_ready`=1.
  - All other outputs 0, including `ALU_Control`=6'b000000.
- **Latency:** accept at edge N; `out_valid` is high from edge N+2. Best-case throughput is one instruction per 3 cycles.
- **Response hold:** response fields and `out_valid` are held unchanged until `out_ready`, with unbounded backpressure allowed. `out_valid` drops on the edge where `out_valid & out_ready`.
- **No overlap:** a new request cannot be accepted in the same cycle a response is consumed.
- **Request inputs:** `instruction`, `pc` and `rs*_data` are sampled only on the accept edge and may change afterwards.
- **ALU inputs:** `ALU_result`/`branch` are sampled only on the EXEC→RESP edge.
- **Reset mid-operation:** any state goes to IDLE immediately and asynchronously. The in-flight transaction is discarded and `out_valid` drops without a handshake.

## Configuration
- **`ALU_ISSUE_ILLEGAL_EN` defined:** an unsupported opcode still takes the IDLE→EXEC→RESP path. The response is:
  - `out_illegal`=1, `out_wb_en`=0, `out_branch_taken`=0, `out_next_pc`=pc+4.
  - ALU driven with 6'b000000, A=B=0.
- **Undefined:** `out_illegal` is tied to 0. An unsupported opcode behaves as the same NOP response without the flag.

## Test plan
- **ADD:** `instruction`=0x002081B3 (add x3,x1,x2), rs1=4, rs2=5.
  - `ALU_Control`=000000.
  - Response 2 cycles later: wb_en=1, rd=3, wb_data=9, next_pc=pc+4.
- **SRAI:** 0x40335293 (srai x5,x6,3), rs1=0xFFFFFC18.
  - `ALU_Control`=001101, operand_B=3.
  - wb_data=0xFFFFFF83, rd=5.
- **BLT:** 0x0020C863 (blt x1,x2,+16), pc=0x100.
  - rs1=0xFFFFFFFE, rs2=0xFFFFFFFF: `ALU_Control`=010100, branch_op=1, taken=1, next_pc=0x110, wb_en=0.
  - Operands swapped: taken=0, next_pc=0x104.
- **JALR:** 0x003280E7 (jalr x1,3(x5)), pc=0x40, rs1=0x201.
  - `ALU_Control`=111111, operand_A=0x44.
  - wb_data=0x44, taken=1, next_pc=0x204.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid`.
  - Response stable and instr_ready=0 throughout.
  - Release: out_valid drops next edge, instr_ready=1.
- **Reset and illegal opcode:**
  - Assert `reset` during EXEC: outputs 0 and instr_ready=1 without a clock edge.
  - Then issue 0x00002003 (lw): with `ALU_ISSUE_ILLEGAL_EN`, out_illegal=1 and wb_en=0; without it, out_illegal=0.
